// File: rtl/count_wrap_pkg.sv
// Shared defaults and event word layout for count_wrap_logger.
package count_wrap_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int TS_W_DEF  = 8;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic                dir;
        logic [TS_W_DEF-1:0] ts;
    } evt_t;

endpackage

// File: rtl/cwl_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data reads 0 while empty.
module cwl_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty    = (level == '0);
        full     = (level == (AW+1)'(DEPTH));
        do_pop   = pop && !empty;
        // A pop frees the slot on the same edge, so a full FIFO can still accept.
        do_push  = push && (!full || do_pop);
        overflow = push && full && !do_pop;
        valid    = !empty;
        rd_data  = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/count_wrap_logger.sv
// Logs timestamped up/down wrap events of a monitored counter into a FWFT FIFO.
// Optional feature: COUNT_WRAP_LOGGER_DROP_CNT_EN adds a saturating drop_cnt output.
module count_wrap_logger
    import count_wrap_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m,
    input  logic [CNT_W-1:0]         count,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W:0]            evt_data,
    output logic                     evt_drop,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef COUNT_WRAP_LOGGER_DROP_CNT_EN
    ,
    output logic [7:0]               drop_cnt
`endif
);

    logic [CNT_W-1:0] prev_count;
    logic             prev_valid;
    logic [TS_W-1:0]  ts;
    logic             wrap;
    logic             overflow;

    // prev_valid gates detection so a pair straddling reset never matches.
    always_comb begin
        wrap = prev_valid &&
               (( m && (prev_count == '1) && (count == '0)) ||
                (!m && (prev_count == '0) && (count == '1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_count <= '0;
            prev_valid <= 1'b0;
            ts         <= '0;
            evt_drop   <= 1'b0;
        end else begin
            prev_count <= count;
            prev_valid <= 1'b1;
            ts         <= ts + 1'b1;
            evt_drop   <= overflow;
        end
    end

    cwl_fifo #(
        .W     (TS_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wrap),
        .push_data ({m, ts}),
        .pop       (evt_ready),
        .valid     (evt_valid),
        .rd_data   (evt_data),
        .level     (fifo_level),
        .overflow  (overflow)
    );

`ifdef COUNT_WRAP_LOGGER_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (evt_drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_count_wrap_logger.sv
// Self-checking bench for count_wrap_logger; scoreboard queue of expected event words.
module tb_count_wrap_logger;
    import count_wrap_pkg::*;

    localparam int DEPTH = DEPTH_DEF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m = 1'b0;
    logic [3:0] count = '0;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [8:0] evt_data;
    logic       evt_drop;
    logic [2:0] fifo_level;
`ifdef COUNT_WRAP_LOGGER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Bench model of the detector and timestamp.
    logic [7:0] mts  = '0;
    logic [3:0] mprev = '0;
    logic       mpv  = 1'b0;
    evt_t       q[$];
    evt_t       last_pop;
    int         n_pop;
    int         n_drop;

    count_wrap_logger #(
        .CNT_W (4),
        .TS_W  (8),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m          (m),
        .count      (count),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .evt_drop   (evt_drop),
        .fifo_level (fifo_level)
`ifdef COUNT_WRAP_LOGGER_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input logic mi, input logic [3:0] ci, input logic rdy);
        logic wrap;
        logic popping;
        logic exp_drop;
        evt_t exp_head;
        m = mi;
        count = ci;
        evt_ready = rdy;
        exp_head = (q.size() != 0) ? q[0] : evt_t'('0);
        n_checks++;
        if (evt_valid !== (q.size() != 0)) begin
            n_fail++;
            $display("FAIL evt_valid: got %b expected %b", evt_valid, q.size() != 0);
        end
        n_checks++;
        if (evt_data !== exp_head) begin
            n_fail++;
            $display("FAIL evt_data: got %h expected %h", evt_data, exp_head);
        end
        popping  = (q.size() != 0) && rdy;
        wrap     = mpv && ((mi && mprev == 4'hF && ci == 4'h0) ||
                           (!mi && mprev == 4'h0 && ci == 4'hF));
        exp_drop = wrap && (q.size() == DEPTH) && !popping;
        if (popping) begin
            last_pop = q.pop_front();
            n_pop++;
        end
        if (wrap && !exp_drop) q.push_back(evt_t'({mi, mts}));
        @(posedge clk);
        #1;
        mprev = ci;
        mpv   = 1'b1;
        mts   = mts + 8'd1;
        n_checks++;
        if (evt_drop !== exp_drop) begin
            n_fail++;
            $display("FAIL evt_drop: got %b expected %b", evt_drop, exp_drop);
        end
        n_checks++;
        if (fifo_level !== 3'(q.size())) begin
            n_fail++;
            $display("FAIL fifo_level: got %0d expected %0d", fifo_level, q.size());
        end
        if (evt_drop === 1'b1) n_drop++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({evt_valid, evt_data, evt_drop, fifo_level} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h drop=%b lvl=%0d expected all 0",
                     evt_valid, evt_data, evt_drop, fifo_level);
        end
`ifdef COUNT_WRAP_LOGGER_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
        end
`endif
        rst = 1'b0;
        q.delete();
        mpv = 1'b0;
        mts = '0;
    endtask

    task automatic test_up_wrap;
        n_pop = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b1);
        step(1'b1, 4'h0, 1'b1);
        repeat (3) step(1'b1, 4'h0, 1'b1);
        n_checks++;
        if (n_pop != 1) begin
            n_fail++;
            $display("FAIL up_wrap_count: got %0d events expected 1", n_pop);
        end
        // The 15->0 pair lands on edge index 16 after reset.
        n_checks++;
        if (last_pop !== evt_t'(9'h110)) begin
            n_fail++;
            $display("FAIL up_wrap_word: got %h expected 110", last_pop);
        end
    endtask

    task automatic test_down_wrap;
        n_pop = 0;
        step(1'b0, 4'h0, 1'b1);
        step(1'b0, 4'hF, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        step(1'b1, 4'hF, 1'b1);
        step(1'b1, 4'hE, 1'b1);
        repeat (3) step(1'b1, 4'hE, 1'b1);
        n_checks++;
        if (n_pop != 1 || last_pop.dir !== 1'b0) begin
            n_fail++;
            $display("FAIL down_wrap: got %0d events dir=%b expected 1 event dir=0", n_pop, last_pop.dir);
        end
    endtask

    task automatic test_backpressure;
        n_drop = 0;
        n_pop = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'hF, 1'b0);
            step(1'b1, 4'h0, 1'b0);
        end
        n_checks++;
        if (fifo_level !== 3'd4 || n_drop != 1) begin
            n_fail++;
            $display("FAIL backpressure_fill: got lvl=%0d drops=%0d expected lvl=4 drops=1", fifo_level, n_drop);
        end
        repeat (6) step(1'b1, 4'h0, 1'b1);
        n_checks++;
        if (n_pop != 4) begin
            n_fail++;
            $display("FAIL backpressure_drain: got %0d events expected 4", n_pop);
        end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] new_ts;
        n_drop = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'hF, 1'b0);
            step(1'b1, 4'h0, 1'b0);
        end
        step(1'b1, 4'hF, 1'b0);
        new_ts = mts;
        step(1'b1, 4'h0, 1'b1);
        n_checks++;
        if (fifo_level !== 3'd4 || n_drop != 0) begin
            n_fail++;
            $display("FAIL full_push_pop: got lvl=%0d drops=%0d expected lvl=4 drops=0", fifo_level, n_drop);
        end
        repeat (5) step(1'b1, 4'h0, 1'b1);
        n_checks++;
        if (last_pop !== evt_t'({1'b1, new_ts})) begin
            n_fail++;
            $display("FAIL full_push_pop_last: got %h expected %h", last_pop, {1'b1, new_ts});
        end
    endtask

    task automatic test_reset_mid;
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'h0, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'h0, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (evt_valid !== 1'b0 || fifo_level !== 3'd0 || evt_data !== 9'd0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b lvl=%0d d=%h expected 0 0 0", evt_valid, fifo_level, evt_data);
        end
        #1;
        rst = 1'b0;
        q.delete();
        mpv = 1'b0;
        mts = '0;
        n_pop = 0;
        step(1'b1, 4'h0, 1'b1);
        repeat (3) step(1'b1, 4'h0, 1'b1);
        n_checks++;
        if (n_pop != 0) begin
            n_fail++;
            $display("FAIL straddle_reset: got %0d events expected 0", n_pop);
        end
    endtask

`ifdef COUNT_WRAP_LOGGER_DROP_CNT_EN
    task automatic test_drop_cnt;
        n_drop = 0;
        for (int i = 0; i < 304; i++) begin
            step(1'b1, 4'hF, 1'b0);
            step(1'b1, 4'h0, 1'b0);
        end
        repeat (2) step(1'b1, 4'h0, 1'b0);
        n_checks++;
        if (drop_cnt !== 8'd255 || n_drop != 300) begin
            n_fail++;
            $display("FAIL drop_cnt: got cnt=%0d drops=%0d expected 255 300", drop_cnt, n_drop);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid();
`ifdef COUNT_WRAP_LOGGER_DROP_CNT_EN
        test_drop_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_wrap_logger.md
COUNT_WRAP_LOGGER -- requirements
Module: count_wrap_logger

Interface
REQ-001 Parameter CNT_W, default 4: width of the monitored count bus, SHALL be at least 2.
REQ-002 Parameter TS_W, default 8: width of the free-running timestamp.
REQ-003 Parameter DEPTH, default 4: event FIFO depth, SHALL be a power of two and at least 2.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port m, input, 1: counter mode, 1 = up and 0 = down, sampled each edge.
REQ-007 Port count, input, CNT_W: the counter value, sampled each edge.
REQ-008 Port evt_valid, output, 1: the FIFO head holds an event.
REQ-009 Port evt_ready, input, 1: the consumer accepts the head.
REQ-010 Port evt_data, output, TS_W+1: event word {dir, ts}, with dir = 1 for an up-wrap.
REQ-011 Port evt_drop, output, 1: one-cycle pulse when an event is lost.
REQ-012 Port fifo_level, output, $clog2(DEPTH)+1: number of stored events.

Function
REQ-013 The block SHALL register prev_count and a prev_valid flag every edge; prev_valid SHALL be set on the first edge after reset.
REQ-014 An up-wrap SHALL be detected when prev_valid=1, m=1, prev_count=all-ones and count=0.
REQ-015 A down-wrap SHALL be detected when prev_valid=1, m=0, prev_count=0 and count=all-ones.
REQ-016 Any other transition SHALL produce no event, including a wrap-shaped pair whose direction disagrees with m, holds, and arbitrary jumps.
REQ-017 Timestamp ts SHALL be a TS_W-bit counter incrementing every cycle and wrapping modulo 2^TS_W.
REQ-018 The event word SHALL carry the ts value present at the detecting edge.
REQ-019 A detected event SHALL be pushed at the detecting edge, so evt_valid is high in the following cycle (latency 1).
REQ-020 The FIFO SHALL be first-word-fall-through: evt_valid = not empty, and evt_data = head entry.
REQ-021 A pop SHALL occur on an edge where evt_valid and evt_ready are both 1.
REQ-022 evt_data SHALL remain stable while evt_valid=1 and evt_ready=0.
REQ-023 When the FIFO is full and a push and pop occur on the same edge, both SHALL complete, the level SHALL be unchanged, and no drop SHALL be flagged.
REQ-024 When the FIFO is full, a push occurs, and there is no pop, the new event SHALL be discarded and evt_drop SHALL pulse for exactly one cycle.
REQ-025 When the FIFO is empty, a push SHALL make evt_valid 1 next cycle, and a pop SHALL not occur on that same edge.
REQ-026 evt_data SHALL be 0 while evt_valid=0.

Reset
REQ-027 Asserting rst SHALL immediately clear prev_count, prev_valid, ts, the FIFO pointers, fifo_level, evt_valid, evt_data and evt_drop to 0.
REQ-028 Reset mid-operation SHALL discard all stored events.
REQ-029 No event SHALL be detected from a value pair straddling reset.

Configuration
REQ-030 Macro COUNT_WRAP_LOGGER_DROP_CNT_EN, when defined, SHALL add an output drop_cnt (8 bits) that increments on each evt_drop pulse, saturates at 255, and resets to 0.
REQ-031 Without the macro, drop_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package count_wrap_pkg SHALL hold the default CNT_W, TS_W and DEPTH constants and the packed typedef evt_t {dir, ts}.
REQ-033 Sub-module cwl_fifo SHALL implement the synchronous FWFT FIFO, covering storage, pointers, level, and the full/empty flags.

Verification
REQ-034 Up-wrap: after reset with m=1 and the counter running 0..15 then 0, with evt_ready=1, exactly one event SHALL appear with dir=1 and ts equal to the cycle index of the 15->0 edge.
REQ-035 Down-wrap: with m=0 and count going 0 -> 15, one event SHALL appear with dir=0; pairs 15->0 under m=0 and 15->14 under m=1 SHALL produce no event.
REQ-036 Back-pressure: with evt_ready=0 and 5 wraps at DEPTH=4, fifo_level SHALL be 4 and a single evt_drop pulse SHALL occur on the 5th wrap; raising evt_ready SHALL then drain 4 events in order with their original ts values.
REQ-037 Full with simultaneous pop and push: level SHALL stay 4, there SHALL be no evt_drop, and the new event SHALL appear last.
REQ-038 Reset with 2 entries stored: evt_valid and fifo_level SHALL be 0 without waiting for a clock edge, and a 15->0 pair across reset release SHALL give no event.
REQ-039 With COUNT_WRAP_LOGGER_DROP_CNT_EN defined and 300 forced drops, drop_cnt SHALL read 255.
